// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
// The slave side is the sequencer and the master side is the datapath or bench.
interface mc_ctrl_if #(parameter int CNT_W = 32);
    logic [31:0]      instr;
    logic             mem_ready;
    logic             pc_en;
    logic             ir_en;
    logic             mem_req;
    logic             MemWrite;
    logic             RegWrite;
    logic             ALUSrc;
    logic             EXTop;
    logic [1:0]       Shiftop;
    logic [1:0]       RegDst;
    logic [1:0]       Memback;
    logic [2:0]       Move;
    logic [2:0]       ALUControl;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;
    logic             illegal;

    modport slave (
        input  instr, mem_ready,
        output pc_en, ir_en, mem_req, MemWrite, RegWrite, ALUSrc, EXTop, Shiftop,
               RegDst, Memback, Move, ALUControl, state, retired, illegal
    );
    modport master (
        output instr, mem_ready,
        input  pc_en, ir_en, mem_req, MemWrite, RegWrite, ALUSrc, EXTop, Shiftop,
               RegDst, Memback, Move, ALUControl, state, retired, illegal
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS datapath.
// Only the state, the retired counter and the illegal flag are registered.
module mc_ctrl #(parameter int CNT_W = 32) (
    input  logic      clk,
    input  logic      reset,
    mc_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_retired;
    logic             r_illegal;

    logic [5:0] w_op, w_funct;
    logic w_nop, w_rtype, w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;
    logic w_legal, w_ctl_en;
    logic w_pc, w_ir, w_mreq, w_mw, w_rw;
    logic w_alusrc, w_extop;
    logic [1:0] w_shiftop, w_regdst, w_memback;
    logic [2:0] w_move, w_aluctl;

    assign w_op    = bus.instr[31:26];
    assign w_funct = bus.instr[5:0];
    assign w_nop   = (bus.instr == 32'd0);
    assign w_rtype = (w_op == 6'b000000);
    assign w_addu  = w_rtype && (w_funct == 6'b100001);
    assign w_subu  = w_rtype && (w_funct == 6'b100011);
    assign w_jr    = w_rtype && (w_funct == 6'b001000);
    assign w_ori   = (w_op == 6'b001101);
    assign w_lui   = (w_op == 6'b001111);
    assign w_lw    = (w_op == 6'b100011);
    assign w_sw    = (w_op == 6'b101011);
    assign w_beq   = (w_op == 6'b000100);
    assign w_j     = (w_op == 6'b000010);
    assign w_jal   = (w_op == 6'b000011);
    assign w_legal = w_nop | w_addu | w_subu | w_jr | w_ori | w_lui | w_lw | w_sw |
                     w_beq | w_j | w_jal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_pc)
                r_retired <= r_retired + CNT_W'(1);
            if (r_state == S_DECODE && !w_legal)
                r_illegal <= 1'b1;
        end
    end

    // pc_en marks the last state of each instruction's path
    always_comb begin
        w_next = S_FETCH;
        w_pc   = 1'b0;
        w_ir   = 1'b0;
        w_mreq = 1'b0;
        w_mw   = 1'b0;
        w_rw   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir   = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_jal)
                    w_next = S_WB;
                else if (w_addu | w_subu | w_ori | w_lui | w_lw | w_sw | w_beq | w_jr)
                    w_next = S_EXEC;
                else
                    w_pc = 1'b1;
            end
            S_EXEC: begin
                if (w_lw | w_sw)
                    w_next = S_MEM;
                else if (w_beq | w_jr)
                    w_pc = 1'b1;
                else
                    w_next = S_WB;
            end
            S_MEM: begin
                w_mreq = 1'b1;
                w_mw   = w_sw;
                if (!bus.mem_ready)
                    w_next = S_MEM;
                else if (w_lw)
                    w_next = S_WB;
                else
                    w_pc = 1'b1;
            end
            S_WB: begin
                w_rw = 1'b1;
                w_pc = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_ctl_en = reset && (r_state == S_DECODE || r_state == S_EXEC ||
                                r_state == S_MEM || r_state == S_WB);

    always_comb begin
        w_alusrc  = 1'b0;
        w_extop   = 1'b0;
        w_shiftop = 2'b00;
        w_regdst  = 2'b00;
        w_memback = 2'b00;
        w_move    = 3'b000;
        w_aluctl  = 3'b000;
        if (w_ctl_en) begin
            if (w_addu | w_subu) begin
                w_regdst = 2'b01;
                w_aluctl = w_subu ? 3'b001 : 3'b000;
            end else if (w_ori | w_lui) begin
                w_alusrc  = 1'b1;
                w_aluctl  = 3'b010;
                w_shiftop = w_lui ? 2'b01 : 2'b00;
            end else if (w_lw | w_sw) begin
                w_alusrc  = 1'b1;
                w_extop   = 1'b1;
                w_memback = w_lw ? 2'b01 : 2'b00;
            end else if (w_beq) begin
                w_extop  = 1'b1;
                w_aluctl = 3'b001;
                w_move   = 3'b001;
            end else if (w_j) begin
                w_move = 3'b010;
            end else if (w_jal) begin
                w_move    = 3'b010;
                w_regdst  = 2'b10;
                w_memback = 2'b10;
            end else if (w_jr) begin
                w_move = 3'b011;
            end
        end
    end

    // Strobes are gated by reset so an asserted reset silences them at once
    assign bus.pc_en      = reset & w_pc;
    assign bus.ir_en      = reset & w_ir;
    assign bus.mem_req    = reset & w_mreq;
    assign bus.MemWrite   = reset & w_mw;
    assign bus.RegWrite   = reset & w_rw;
    assign bus.ALUSrc     = w_alusrc;
    assign bus.EXTop      = w_extop;
    assign bus.Shiftop    = w_shiftop;
    assign bus.RegDst     = w_regdst;
    assign bus.Memback    = w_memback;
    assign bus.Move       = w_move;
    assign bus.ALUControl = w_aluctl;
    assign bus.state      = r_state;
    assign bus.retired    = r_retired;
    assign bus.illegal    = r_illegal;
endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed test-plan steps followed by random instruction streams,
// all checked against a per-instruction path/control table model.
module tb_mc_ctrl;
    typedef enum int {K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ,
                      K_J, K_JAL, K_NOP, K_ILL} kind_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst4 = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] exp_ret = 0;
    logic        exp_ill = 1'b0;

    always #5 clk = ~clk;

    mc_ctrl_if #(.CNT_W(32)) b ();
    mc_ctrl_if #(.CNT_W(4))  b4 ();

    mc_ctrl #(.CNT_W(32)) dut  (.clk(clk), .reset(rst),  .bus(b));
    mc_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .reset(rst4), .bus(b4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {ALUSrc, EXTop, Shiftop, RegDst, Memback, Move, ALUControl}
    function automatic logic [13:0] ctl_now();
        return {b.ALUSrc, b.EXTop, b.Shiftop, b.RegDst, b.Memback, b.Move, b.ALUControl};
    endfunction

    function automatic logic [13:0] ctl_of(kind_t k);
        case (k)
            K_ADDU: return {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 3'b000, 3'b000};
            K_SUBU: return {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 3'b000, 3'b001};
            K_ORI:  return {1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b010};
            K_LUI:  return {1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 3'b010};
            K_LW:   return {1'b1, 1'b1, 2'b00, 2'b00, 2'b01, 3'b000, 3'b000};
            K_SW:   return {1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
            K_BEQ:  return {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b001, 3'b001};
            K_J:    return {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b010, 3'b000};
            K_JAL:  return {1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 3'b010, 3'b000};
            K_JR:   return {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b011, 3'b000};
            default: return 14'd0;
        endcase
    endfunction

    function automatic logic [31:0] gen_instr(kind_t k);
        logic [31:0] r;
        logic [5:0]  op;
        logic [5:0]  fn;
        r = $urandom;
        case (k)
            K_ADDU: return {6'd0, r[25:6], 6'h21};
            K_SUBU: return {6'd0, r[25:6], 6'h23};
            K_JR:   return {6'd0, r[25:6], 6'h08};
            K_ORI:  return {6'h0D, r[25:0]};
            K_LUI:  return {6'h0F, r[25:0]};
            K_LW:   return {6'h23, r[25:0]};
            K_SW:   return {6'h2B, r[25:0]};
            K_BEQ:  return {6'h04, r[25:0]};
            K_J:    return {6'h02, r[25:0]};
            K_JAL:  return {6'h03, r[25:0]};
            K_NOP:  return 32'd0;
            default: begin
                if (r[31]) begin
                    do op = 6'($urandom);
                    while (op inside {6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03});
                    return {op, r[25:0]};
                end else begin
                    do fn = 6'($urandom);
                    while (fn inside {6'h21, 6'h23, 6'h08});
                    return {6'd0, r[25:12], 1'b1, r[10:6], fn};
                end
            end
        endcase
    endfunction

    // Run one instruction from its FETCH cycle; stalls = mem_ready-low cycles in MEM
    task automatic run(input kind_t k, input logic [31:0] ins, input int stalls, input string nm);
        int path[$];
        int st;
        int mem_seen;
        bit last;
        case (k)
            K_ADDU, K_SUBU, K_ORI, K_LUI: path = '{0, 1, 2, 4};
            K_LW:                         path = '{0, 1, 2, 3, 4};
            K_SW:                         path = '{0, 1, 2, 3};
            K_BEQ, K_JR:                  path = '{0, 1, 2};
            K_JAL:                        path = '{0, 1, 4};
            default:                      path = '{0, 1};
        endcase
        for (int i = 0; i < path.size(); i++) begin
            if (path[i] == 3) begin
                for (int s = 0; s < stalls; s++) path.insert(i, 3);
                break;
            end
        end
        mem_seen = 0;
        b.instr = ins;
        for (int i = 0; i < path.size(); i++) begin
            st   = path[i];
            last = (i == path.size() - 1);
            if (st == 3) begin
                b.mem_ready = (mem_seen >= stalls);
                mem_seen++;
            end else begin
                b.mem_ready = 1'($urandom);
            end
            #1;
            chk({nm, ".state"},    32'(b.state),    32'(st));
            chk({nm, ".pc_en"},    32'(b.pc_en),    32'(last));
            chk({nm, ".ir_en"},    32'(b.ir_en),    32'(st == 0));
            chk({nm, ".mem_req"},  32'(b.mem_req),  32'(st == 3));
            chk({nm, ".MemWrite"}, 32'(b.MemWrite), 32'(st == 3 && k == K_SW));
            chk({nm, ".RegWrite"}, 32'(b.RegWrite), 32'(st == 4));
            chk({nm, ".ctl"},      32'(ctl_now()),  32'((st == 0) ? 14'd0 : ctl_of(k)));
            chk({nm, ".retired"},  b.retired,       exp_ret);
            chk({nm, ".illegal"},  32'(b.illegal),  32'(exp_ill));
            if (last) exp_ret = exp_ret + 1;
            if (st == 1 && k == K_ILL) exp_ill = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, ".state"},   32'(b.state),   32'd0);
        chk({nm, ".retired"}, b.retired,      32'd0);
        chk({nm, ".illegal"}, 32'(b.illegal), 32'd0);
        chk({nm, ".strobes"}, 32'({b.pc_en, b.ir_en, b.mem_req, b.MemWrite, b.RegWrite}), 32'd0);
        chk({nm, ".ctl"},     32'(ctl_now()), 32'd0);
    endtask

    initial begin
        kind_t k;
        int    stl;
        b.instr = 32'd0;
        b.mem_ready = 1'b1;
        b4.instr = 32'd0;
        b4.mem_ready = 1'b1;

        // power-on reset
        repeat (2) @(negedge clk);
        #1 chk_reset("por");
        @(negedge clk);
        rst = 1'b1;

        run(K_ADDU, 32'h00221821, 0, "addu");
        run(K_LW,   32'h8C430004, 2, "lw_stall");
        run(K_SW,   32'hAC430008, 0, "sw");
        run(K_JAL,  32'h0C000010, 0, "jal");
        run(K_BEQ,  32'h10220003, 0, "beq");
        run(K_J,    32'h08000000, 0, "j");
        run(K_ILL,  32'hFC000000, 0, "ill");
        run(K_NOP,  32'h00000000, 0, "nop");
        chk("ret_after_directed", b.retired, 32'd8);

        for (int n = 0; n < 80; n++) begin
            k   = kind_t'($urandom_range(0, 11));
            stl = (k == K_LW || k == K_SW) ? int'($urandom_range(0, 3)) : 0;
            run(k, gen_instr(k), stl, "rnd");
        end

        // reset pulsed during EXEC of an addu
        b.instr = 32'h00221821;
        b.mem_ready = 1'b1;
        #1 chk("rmid.f", 32'(b.state), 32'd0);
        @(negedge clk);
        #1 chk("rmid.d", 32'(b.state), 32'd1);
        @(negedge clk);
        #1 chk("rmid.e", 32'(b.state), 32'd2);
        rst = 1'b0;
        #1 chk_reset("rmid.r0");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 chk_reset("rmid.rN");
        end
        @(negedge clk);
        rst = 1'b1;
        exp_ret = 0;
        exp_ill = 1'b0;
        #1 chk("rmid.first_ir_en", 32'(b.ir_en), 32'd1);
        run(K_ADDU, 32'h00221821, 0, "addu_after_rst");
        chk("rmid.ret", b.retired, 32'd1);

        // 4-bit counter wrap on a stream of nops
        @(negedge clk);
        rst4 = 1'b1;
        repeat (32) @(negedge clk);
        #1 chk("wrap16", 32'(b4.retired), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 chk("wrap17", 32'(b4.retired), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle sequencer for the single-cycle MIPS datapath, extended with PC and IR write enables. Decodes the instruction register, steps each instruction through FETCH/DECODE/EXEC/MEM/WB, and drives every datapath control at the correct cycle. It waits on a data-memory ready handshake, counts retired instructions and flags unsupported encodings.

## Interface
- CNT_W, 32, width of retired-instruction counter

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low (reset=0 resets)
- instr  in  32  IR contents from datapath (valid from DECODE on)
- mem_ready  in  1  data memory done; sampled only in MEM
- pc_en  out  1  PC loads NPC at this edge
- ir_en  out  1  IR loads IMEM output at this edge
- mem_req  out  1  data-memory access active
- MemWrite  out  1  DM write strobe
- RegWrite  out  1  GRF write strobe
- ALUSrc  out  1  0=RD2, 1=ext_imm
- EXTop  out  1  0=zero-extend, 1=sign-extend
- Shiftop  out  2  00=none, 01=shift left 16 (lui)
- RegDst  out  2  00=rt, 01=rd, 10=$31
- Memback  out  2  00=ALU, 01=DM, 10=PC+4
- Move  out  3  000=PC+4, 001=beq (Cmp equal), 010=instr_index, 011=GRF_rs
- ALUControl  out  3  000=add, 001=sub, 010=or
- state  out  3  current state
- retired  out  CNT_W  instructions completed, wraps
- illegal  out  1  sticky unsupported-encoding flag

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5–7 go to FETCH next cycle, with all strobes 0.
- Supported: addu (R, funct 100001), subu (100011), jr (001000), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011. instr==0 is a nop.
- Paths:
  - addu/subu/ori/lui: F→D→E→WB.
  - lw: F→D→E→MEM→WB.
  - sw: F→D→E→MEM.
  - beq and jr: F→D→E.
  - jal: F→D→WB.
  - j, nop and illegal: F→D.
- FETCH: ir_en=1; all other strobes 0; controls 0.
- DECODE onward: static controls come from instr, held constant until FETCH.
  - addu/subu: RegDst=01, ALUSrc=0, ALU add/sub.
  - ori: EXTop=0, ALUSrc=1, or, RegDst=00.
  - lui: Shiftop=01, ALUSrc=1, or, RegDst=00.
  - lw/sw: EXTop=1, ALUSrc=1, add. lw also uses Memback=01.
  - beq: EXTop=1, sub, Move=001.
  - j: Move=010.
  - jal: Move=010, RegDst=10, Memback=10.
  - jr: Move=011.
- RegWrite is 1 only in WB.
- MemWrite is 1 only in MEM for sw.
- mem_req is 1 for the whole of MEM.
- MEM stays in MEM while mem_ready=0. It exits on the cycle mem_ready=1: lw goes to WB, sw goes to FETCH.
- pc_en=1 in exactly one cycle per instruction, the last state of its path. For jal that is WB, so Memback=10 sees the old PC.
- retired increments on every pc_en cycle and wraps modulo 2^CNT_W.
- illegal: any other opcode, or R-type with any other funct (except instr==0).
  - Sets in DECODE.
  - Instruction is treated as a nop: Move=000, pc_en=1.
  - Stays set until reset.

## Timing
- Reset (reset=0, async): state=FETCH, retired=0, illegal=0.
  - While reset=0, all strobes are forced 0: pc_en, ir_en, mem_req, MemWrite, RegWrite.
  - All control outputs are 0.
  - First ir_en occurs in the first cycle after release.
- All outputs are combinational from state and instr. Only state, retired and illegal are registered.
- Latency in cycles, with mem_ready tied high:
  - addu/subu/ori/lui/sw: 4
  - lw: 5
  - beq/jr/jal: 3
  - j/nop/illegal: 2
  - Each cycle of mem_ready=0 in MEM adds one.
- mem_ready outside MEM is ignored.
- Reset asserted mid-MEM drops mem_req and MemWrite immediately. The instruction does not retire.

## Test plan
- Reset mid-instruction:
  - Stimulus: pulse reset=0 for 3 cycles in EXEC.
  - Required: state=0, retired=0, all strobes 0 during reset; ir_en=1 on the first cycle after release.
- addu 0x00221821:
  - Required: states 0,1,2,4; RegWrite=1 and pc_en=1 only in WB; RegDst=01; retired 0→1.
- lw 0x8C430004 with mem_ready low for 2 MEM cycles:
  - Required: MEM held 3 cycles with mem_req=1; Memback=01; WB follows; total 7 cycles.
- sw 0xAC430008 then jal 0x0C000010:
  - Required for sw: MemWrite=1 only in MEM; 4 cycles.
  - Required for jal: D then WB; WB has RegDst=10, Memback=10, Move=010, RegWrite=1, pc_en=1.
- beq 0x10220003 then j 0x08000000:
  - Required for beq: pc_en in EXEC with ALUControl=001 and Move=001.
  - Required for j: pc_en in DECODE with Move=010.
- Illegal instr 0xFC000000 then nop 0x00000000:
  - Required: illegal rises in DECODE and stays 1 across the nop; each instruction takes 2 cycles; retired increments by 2.
- Counter wrap with CNT_W=4:
  - Stimulus: 17 nops.
  - Required: retired=1.
